// File: rtl/reg_acc_pkg.sv
// Shared types for the register-access arbiter: FSM states, access source, gap counter width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package reg_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_SPI = 1'b0,
    SRC_TST = 1'b1
  } src_t;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/reg_acc_arb_arb2_rr.sv
// Two-input grant between SPI and test requesters; round-robin on ties (fixed SPI priority with REG_ACC_ARB_FIXED_PRI_EN).
// Latency: grant is combinational from the requests; last_grant updates one cycle after i_upd.
// Backpressure: none; the caller decides when a grant is taken and reports it through i_upd.
module arb2_rr
  import reg_acc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_spi_req,
  input  logic i_tst_req,
  input  logic i_upd,
  input  src_t i_upd_src,
  output logic o_gnt_vld,
  output src_t o_gnt_src
);

  assign o_gnt_vld = i_spi_req | i_tst_req;

`ifdef REG_ACC_ARB_FIXED_PRI_EN

  // history inputs have no use when SPI always wins a tie
  logic unused_hist;
  assign unused_hist = ^{i_clk, i_rst_n, i_upd, i_upd_src};

  // SPI wins whenever it is requesting
  always_comb begin
    o_gnt_src = SRC_SPI;
    if (i_tst_req && !i_spi_req) o_gnt_src = SRC_TST;
  end

`else

  src_t last_grant;

  // remember who was served last; resets to TST so SPI wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_grant <= SRC_TST;
    else if (i_upd) last_grant <= i_upd_src;
  end

  // single requester wins outright; on a tie serve the port not served last
  always_comb begin
    o_gnt_src = SRC_SPI;
    if (i_spi_req && i_tst_req) o_gnt_src = (last_grant == SRC_SPI) ? SRC_TST : SRC_SPI;
    else if (i_tst_req) o_gnt_src = SRC_TST;
  end

`endif

endmodule

// File: rtl/reg_acc_arb.sv
// Shares the register-file ren/wen bus between SPI and test requesters; REG_ACC_ARB_FIXED_PRI_EN selects fixed SPI priority.
// Latency: req sampled at edge N -> strobe in cycle N+1 -> ack in cycle N+2; one access per 3+GAP_CYC cycles.
// Backpressure: requesters hold req (level) until ack; requests are ignored outside IDLE.
module reg_acc_arb
  import reg_acc_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int GAP_CYC = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_spi_req,
  input  logic          i_spi_wr,
  input  logic [AW-1:0] i_spi_addr,
  input  logic [DW-1:0] i_spi_wdata,
  output logic          o_spi_ack,
  output logic [DW-1:0] o_spi_rdata,
  input  logic          i_tst_req,
  input  logic          i_tst_wr,
  input  logic [AW-1:0] i_tst_addr,
  input  logic [DW-1:0] i_tst_wdata,
  output logic          o_tst_ack,
  output logic [DW-1:0] o_tst_rdata,
  output logic          o_ren,
  output logic          o_wen,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  output logic          o_src_tst,
  input  logic [DW-1:0] i_rdata,
  output logic          o_busy
);

  // GAP lasts GAP_CYC cycles: counter loaded with GAP_CYC-1 and leaves at zero
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t                 state;
  state_t                 state_nxt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   gnt_vld;
  src_t                   gnt_src;
  src_t                   src_q;
  logic                   sel_wr;
  logic [AW-1:0]          sel_addr;
  logic [DW-1:0]          sel_wdata;

  arb2_rr u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_spi_req (i_spi_req),
    .i_tst_req (i_tst_req),
    .i_upd     (state == ACC),
    .i_upd_src (src_q),
    .o_gnt_vld (gnt_vld),
    .o_gnt_src (gnt_src)
  );

  assign o_src_tst = (src_q == SRC_TST);

  // steer the winning port's command onto the bus-register inputs
  always_comb begin
    sel_wr    = i_spi_wr;
    sel_addr  = i_spi_addr;
    sel_wdata = i_spi_wdata;
    if (gnt_src == SRC_TST) begin
      sel_wr    = i_tst_wr;
      sel_addr  = i_tst_addr;
      sel_wdata = i_tst_wdata;
    end
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: IDLE -> ACC -> ACK -> (GAP ->) IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ACC;
      ACC:     state_nxt = ACK;
      ACK:     state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // registered bus strobes, acks, read capture and gap counter; everything is driven from flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q       <= SRC_SPI;
      o_ren       <= 1'b0;
      o_wen       <= 1'b0;
      o_addr      <= '0;
      o_wdata     <= '0;
      o_spi_ack   <= 1'b0;
      o_tst_ack   <= 1'b0;
      o_spi_rdata <= '0;
      o_tst_rdata <= '0;
      o_busy      <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      o_ren     <= 1'b0;
      o_wen     <= 1'b0;
      o_spi_ack <= 1'b0;
      o_tst_ack <= 1'b0;
      o_busy    <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            src_q   <= gnt_src;
            o_addr  <= sel_addr;
            o_wdata <= sel_wdata;
            o_ren   <= ~sel_wr;
            o_wen   <= sel_wr;
          end
        end
        ACC: begin
          // the access is committed here: ack follows even if req has dropped
          if (src_q == SRC_TST) begin
            o_tst_ack <= 1'b1;
            if (o_ren) o_tst_rdata <= i_rdata;
          end else begin
            o_spi_ack <= 1'b1;
            if (o_ren) o_spi_rdata <= i_rdata;
          end
        end
        ACK: begin
          gap_cnt <= GAP_LOAD;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          gap_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_acc_arb.sv
// Scoreboard bench for reg_acc_arb: DUT 0 built with GAP_CYC=1, DUT 1 with GAP_CYC=3.
// Latency: expected strobes/acks are queued at stimulus time and checked as the DUTs produce them.
// Backpressure: requests held until ack, then dropped in the ack cycle.
module tb_reg_acc_arb;

  typedef struct {
    int         d;
    bit         src;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } strb_t;

  typedef struct {
    int         d;
    bit         src;
    bit         rd;
    logic [7:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      spi_req = '0, spi_wr = '0, tst_req = '0, tst_wr = '0;
  logic [1:0][7:0] spi_addr = '0, spi_wdata = '0, tst_addr = '0, tst_wdata = '0;
  logic [1:0][7:0] bus_rdata;
  wire  [1:0]      spi_ack, tst_ack, ren, wen, src_tst, busy;
  wire  [1:0][7:0] spi_rdata, tst_rdata, addr, wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  strb_t sq[$];
  ack_t  aq[$];
  int    st_q[$];
  logic [1:0][7:0] m_spi = '0, m_tst = '0;

  function automatic logic [7:0] rd_val(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h84;
  endfunction

  // slice read data is only meaningful while ren is high; otherwise present a wrong value
  assign bus_rdata[0] = ren[0] ? rd_val(addr[0]) : ~rd_val(addr[0]);
  assign bus_rdata[1] = ren[1] ? rd_val(addr[1]) : ~rd_val(addr[1]);

  reg_acc_arb #(.DW(8), .AW(8), .GAP_CYC(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spi_req(spi_req[0]), .i_spi_wr(spi_wr[0]), .i_spi_addr(spi_addr[0]), .i_spi_wdata(spi_wdata[0]),
    .o_spi_ack(spi_ack[0]), .o_spi_rdata(spi_rdata[0]),
    .i_tst_req(tst_req[0]), .i_tst_wr(tst_wr[0]), .i_tst_addr(tst_addr[0]), .i_tst_wdata(tst_wdata[0]),
    .o_tst_ack(tst_ack[0]), .o_tst_rdata(tst_rdata[0]),
    .o_ren(ren[0]), .o_wen(wen[0]), .o_addr(addr[0]), .o_wdata(wdata[0]),
    .o_src_tst(src_tst[0]), .i_rdata(bus_rdata[0]), .o_busy(busy[0])
  );

  reg_acc_arb #(.DW(8), .AW(8), .GAP_CYC(3)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_spi_req(spi_req[1]), .i_spi_wr(spi_wr[1]), .i_spi_addr(spi_addr[1]), .i_spi_wdata(spi_wdata[1]),
    .o_spi_ack(spi_ack[1]), .o_spi_rdata(spi_rdata[1]),
    .i_tst_req(tst_req[1]), .i_tst_wr(tst_wr[1]), .i_tst_addr(tst_addr[1]), .i_tst_wdata(tst_wdata[1]),
    .o_tst_ack(tst_ack[1]), .o_tst_rdata(tst_rdata[1]),
    .o_ren(ren[1]), .o_wen(wen[1]), .o_addr(addr[1]), .o_wdata(wdata[1]),
    .o_src_tst(src_tst[1]), .i_rdata(bus_rdata[1]), .o_busy(busy[1])
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard: every strobe and ack must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ren[d] | wen[d]) begin
          if (sq.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            strb_t e;
            e = sq.pop_front();
            chk("strb_dut", d, e.d);
            chk("strb_both", ren[d] & wen[d], 0);
            chk("strb_wen", wen[d], e.wr);
            chk("strb_addr", addr[d], e.addr);
            if (e.wr) chk("strb_wdata", wdata[d], e.wdata);
            chk("strb_src", src_tst[d], e.src);
            st_q.push_back(cyc);
          end
        end
        if (spi_ack[d] | tst_ack[d]) begin
          if (aq.size() == 0) chk("unexpected_ack", 1, 0);
          else begin
            ack_t a;
            a = aq.pop_front();
            chk("ack_dut", d, a.d);
            chk("ack_port", {tst_ack[d], spi_ack[d]}, a.src ? 2 : 1);
            chk("ack_strobe_low", ren[d] | wen[d], 0);
            if (a.rd) begin
              if (a.src) m_tst[a.d] = a.rdata;
              else       m_spi[a.d] = a.rdata;
            end
            chk("spi_rdata", spi_rdata[d], m_spi[d]);
            chk("tst_rdata", tst_rdata[d], m_tst[d]);
          end
        end
      end
    end
  end

  task automatic drive(input int d, input bit src, input bit req, input bit wr,
                       input logic [7:0] a, input logic [7:0] w);
    if (src) begin
      tst_req[d] = req; tst_wr[d] = wr; tst_addr[d] = a; tst_wdata[d] = w;
    end else begin
      spi_req[d] = req; spi_wr[d] = wr; spi_addr[d] = a; spi_wdata[d] = w;
    end
  endtask

  function automatic ack_t mk_ack(input int d, input bit src, input bit wr, input logic [7:0] a);
    ack_t r;
    r.d = d; r.src = src; r.rd = !wr; r.rdata = rd_val(a);
    return r;
  endfunction

  // single-port access from idle: strobe after one edge, ack after two
  task automatic access(input int d, input bit src, input bit wr, input logic [7:0] a, input logic [7:0] w);
    int n;
    bit got;
    repeat (4) @(negedge clk);
    sq.push_back('{d, src, wr, a, w});
    aq.push_back(mk_ack(d, src, wr, a));
    drive(d, src, 1'b1, wr, a, w);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = src ? tst_ack[d] : spi_ack[d];
    end
    chk("ack_latency", n, 2);
    drive(d, src, 1'b0, wr, a, w);
  endtask

  initial begin
    int acks;
    int n;
    bit got;

    // reset state on both instances
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("reset_outputs", {ren[d], wen[d], spi_ack[d], tst_ack[d], spi_rdata[d], tst_rdata[d],
                            addr[d], wdata[d], src_tst[d], busy[d]}, 0);
    rst_n = 1'b1;

    // SPI read of 0x12 returns 0xA5 and holds it
    access(0, 1'b0, 1'b0, 8'h12, 8'h00);
    repeat (3) @(negedge clk);
    chk("t1_rdata_hold", spi_rdata[0], 8'hA5);
    chk("t1_idle", busy[0], 0);

    // test-port write leaves test rdata untouched
    access(0, 1'b1, 1'b1, 8'h30, 8'h5A);
    repeat (2) @(negedge clk);
    chk("t2_tst_rdata", tst_rdata[0], 8'h00);

    // both ports requesting continuously: four accesses
    repeat (4) @(negedge clk);
    st_q.delete();
`ifdef REG_ACC_ARB_FIXED_PRI_EN
    for (int i = 0; i < 4; i++) begin
      sq.push_back('{0, 1'b0, 1'b0, 8'h70, 8'h00});
      aq.push_back(mk_ack(0, 1'b0, 1'b0, 8'h70));
    end
`else
    for (int i = 0; i < 2; i++) begin
      sq.push_back('{0, 1'b0, 1'b0, 8'h70, 8'h00});
      aq.push_back(mk_ack(0, 1'b0, 1'b0, 8'h70));
      sq.push_back('{0, 1'b1, 1'b0, 8'h0F, 8'h00});
      aq.push_back(mk_ack(0, 1'b1, 1'b0, 8'h0F));
    end
`endif
    drive(0, 1'b0, 1'b1, 1'b0, 8'h70, 8'h00);
    drive(0, 1'b1, 1'b1, 1'b0, 8'h0F, 8'h00);
    acks = 0;
    n = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (spi_ack[0] | tst_ack[0]) acks++;
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h70, 8'h00);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h0F, 8'h00);
    chk("t3_acks", acks, 4);
    chk("t3_strobes", st_q.size(), 4);
    if (st_q.size() == 4)
      for (int i = 0; i < 3; i++) chk("t3_spacing", st_q[i+1] - st_q[i], 4);

    // GAP_CYC=3: request arriving during GAP waits for IDLE
    st_q.delete();
    access(1, 1'b0, 1'b0, 8'h21, 8'h00);
    @(negedge clk);
    chk("t4_busy_in_gap", busy[1], 1);
    sq.push_back('{1, 1'b1, 1'b1, 8'h66, 8'hC3});
    aq.push_back(mk_ack(1, 1'b1, 1'b1, 8'h66));
    drive(1, 1'b1, 1'b1, 1'b1, 8'h66, 8'hC3);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = tst_ack[1];
    end
    drive(1, 1'b1, 1'b0, 1'b1, 8'h66, 8'hC3);
    chk("t4_ack_seen", got, 1);
    chk("t4_strobes", st_q.size(), 2);
    if (st_q.size() == 2) chk("t4_spacing", st_q[1] - st_q[0], 6);

    // reset in the ACC cycle of an SPI read
    repeat (6) @(negedge clk);
    sq.push_back('{0, 1'b0, 1'b0, 8'h44, 8'h00});
    drive(0, 1'b0, 1'b1, 1'b0, 8'h44, 8'h00);
    @(negedge clk);
    chk("t5_in_acc", ren[0], 1);
    #2;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h44, 8'h00);
    #1;
    chk("t5_reset_outputs", {ren[0], wen[0], spi_ack[0], tst_ack[0], spi_rdata[0], tst_rdata[0],
                             addr[0], src_tst[0], busy[0]}, 0);
    m_spi = '0;
    m_tst = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_no_ack_after_release", spi_ack[0], 0);
    access(0, 1'b0, 1'b0, 8'h44, 8'h00);
    chk("t5_fresh_rdata", spi_rdata[0], rd_val(8'h44));

    // SPI req dropped during ACC: access still completes, no retry
    repeat (4) @(negedge clk);
    sq.push_back('{0, 1'b0, 1'b0, 8'h5C, 8'h00});
    aq.push_back(mk_ack(0, 1'b0, 1'b0, 8'h5C));
    drive(0, 1'b0, 1'b1, 1'b0, 8'h5C, 8'h00);
    @(negedge clk);
    chk("t6_strobe", ren[0], 1);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h5C, 8'h00);
    @(negedge clk);
    chk("t6_ack", spi_ack[0], 1);
    repeat (6) @(negedge clk);
    chk("t6_idle", busy[0], 0);

    chk("strobe_queue_empty", sq.size(), 0);
    chk("ack_queue_empty", aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
